oled_spi_decoder: RTL
=====================

// Module: oled_spi_decoder
// PURPOSE
// - Downstream consumer of the OLED manager's 4-wire serial link (nCS, DnC, SDIN, SCLK).
// - Deserialises bytes MSB-first and decodes SetX (0x15), SetY (0x75) and SetPixel (0x5C).
// - Tracks the column/row window and the pixel cursor; emits one pixel-write strobe per 16-bit colour.
// - Used as an on-chip display mirror / self-check monitor, on the same HCLK as the manager.
// PARAMETERS
// - X_MAX  95  last valid column; x fields are 7 bit
// - Y_MAX  63  last valid row; y fields are 6 bit
// PORTS
// - HCLK        in   1   system clock
// - HRESET      in   1   reset, synchronous, active-high
// - nCS         in   1   chip select, active low; may rise between bytes
// - DnC         in   1   0 = command byte, 1 = data byte
// - SDIN        in   1   serial data, MSB first
// - SCLK        in   1   serial clock; high for >=1 HCLK per bit
// - pix_valid   out  1   1-cycle strobe: pixel write decoded
// - pix_x       out  7   pixel column, valid with pix_valid
// - pix_y       out  6   pixel row, valid with pix_valid
// - pix_colour  out  16  {first byte, second byte}, valid with pix_valid
// - cmd_valid   out  1   1-cycle strobe: command byte received
// - cmd_byte    out  8   last command byte, held until the next command
// - frag_err    out  1   1-cycle strobe: partial byte discarded
// BEHAVIOUR
// - Reset (synchronous, HRESET=1 at posedge HCLK): every output is 0; bit_cnt=0; state=IDLE.
// - Reset window: x 0..X_MAX, y 0..Y_MAX; cursor (0,0). Reset mid-byte discards the partial byte.
// - Input stage: nCS, DnC, SDIN, SCLK are registered once. A bit is taken on a registered SCLK 0->1 while registered nCS=0.
// - Bit handling: shift SDIN into sr[7:0] and increment bit_cnt 0..7. At bit 8 the byte completes, bit_cnt wraps to 0, and DnC is sampled with that bit.
// - Registered nCS 0->1 with bit_cnt!=0: clear bit_cnt, discard sr, pulse frag_err. The same event with bit_cnt=0 is legal and silent.
// - Command byte (DnC=0): always accepted regardless of state; pulse cmd_valid and load cmd_byte.
//   - 0x15 -> X_START.
//   - 0x75 -> Y_START.
//   - 0x5C -> PIX_HI; cursor := (x_start, y_start).
//   - any other value -> IDLE.
// - Data byte (DnC=1), by state:
//   - IDLE: ignored.
//   - X_START: x_start := min(byte, X_MAX) -> X_END.
//   - X_END: x_end := max(min(byte, X_MAX), x_start) -> IDLE.
//   - Y_START / Y_END: same rules as X, using Y_MAX.
//   - PIX_HI: hold byte -> PIX_LO.
//   - PIX_LO: pulse pix_valid with the current cursor and colour {hi, lo}; advance cursor -> PIX_HI.
// - Cursor advance:
//   - x == x_end: x := x_start, then y steps.
//   - otherwise: x++.
//   - y step: y == y_end gives y := y_start (window wrap); otherwise y++.
// - Latency: pix_valid / cmd_valid go high 2 HCLK after the cycle in which SCLK is high for the byte's last bit.
// - Pixel stream: SetPixel stays active for any number of pixels until the next command byte.
// - Simultaneous events: a completing byte and nCS rising in the same cycle give a valid byte and no frag_err.
// - Windows set via SetX/SetY apply only from the next SetPixel; a pixel stream already in progress keeps its cursor.
// CONFIGURATION
// - OLED_DEC_SYNC_EN defined: a 2-flop synchroniser precedes the input register on all four inputs.
//   Link may then be asynchronous to HCLK provided SCLK high/low >= 3 HCLK. Latency becomes 4 HCLK.
// - Undefined: single register stage, same-clock link only, latency 2 HCLK.
// TESTING
// - T1 pixel decode: 15 08 0F (SetX), 75 0D 19 (SetY), 5C, then 06 3C.
//   -> pix_valid once, x=8, y=13, colour=0x063C.
// - T2 window wrap: same window, 105 pixels.
//   -> pixel 9 at (8,14); pixel 104 at (15,25); pixel 105 at (8,13).
// - T3 fragment: nCS rises after 3 bits.
//   -> frag_err high 1 cycle, no strobe; the following byte 0x15 gives cmd_valid with cmd_byte=0x15.
// - T4 unknown command: 0xAF followed by data 06 3C.
//   -> cmd_valid with cmd_byte=0xAF; no pix_valid; state IDLE.
// - T5 reset and clamp: HRESET after 5 bits, then 15 70 05.
//   -> outputs 0 during reset; next byte aligned; x_start=95, x_end=95.
// - T6 latency: measure cmd_valid after the final SCLK high.
//   -> exactly 2 HCLK without OLED_DEC_SYNC_EN, 4 HCLK with it.

Source files
------------

// File: rtl/oled_spi_decoder.sv
// Decodes the OLED 4-wire link into command and pixel-write strobes.
// Define OLED_DEC_SYNC_EN to add a 2-flop input synchroniser.
module oled_spi_decoder #(
  parameter int X_MAX = 95,
  parameter int Y_MAX = 63
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        nCS,
  input  logic        DnC,
  input  logic        SDIN,
  input  logic        SCLK,
  output logic        pix_valid,
  output logic [6:0]  pix_x,
  output logic [5:0]  pix_y,
  output logic [15:0] pix_colour,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        frag_err
);

  typedef enum logic [2:0] {
    IDLE,
    X_START,
    X_END,
    Y_START,
    Y_END,
    PIX_HI,
    PIX_LO
  } state_t;

  logic [3:0] link_in;
  logic [3:0] link_pre;

  assign link_in = {nCS, DnC, SDIN, SCLK};

`ifdef OLED_DEC_SYNC_EN
  logic [3:0] sync1;
  logic [3:0] sync2;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sync1 <= 4'b1000;
      sync2 <= 4'b1000;
    end else begin
      sync1 <= link_in;
      sync2 <= sync1;
    end
  end

  assign link_pre = sync2;
`else
  assign link_pre = link_in;
`endif

  logic cs_r, dc_r, sd_r, sck_r;
  logic cs_d, sck_d;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cs_r  <= 1'b1;
      dc_r  <= 1'b0;
      sd_r  <= 1'b0;
      sck_r <= 1'b0;
      cs_d  <= 1'b1;
      sck_d <= 1'b0;
    end else begin
      {cs_r, dc_r, sd_r, sck_r} <= link_pre;
      cs_d  <= cs_r;
      sck_d <= sck_r;
    end
  end

  state_t     state;
  logic [6:0] sr;
  logic [2:0] bit_cnt;
  logic [6:0] x_start, x_end, cur_x;
  logic [5:0] y_start, y_end, cur_y;
  logic [7:0] hi_byte;

  logic       sck_rise, cs_rise;
  logic       bit_take, last, frag, shift;
  logic [7:0] rx;
  logic [6:0] x_clip;
  logic [5:0] y_clip;

  // A bit edge coinciding with nCS rising still belongs to the byte.
  assign sck_rise = sck_r & ~sck_d;
  assign cs_rise  = cs_r & ~cs_d;
  assign bit_take = sck_rise & (~cs_r | cs_rise);
  assign last     = bit_take & (bit_cnt == 3'd7);
  assign frag     = cs_rise & ~last & ((bit_cnt != 3'd0) | bit_take);
  assign shift    = bit_take & ~frag;
  assign rx       = {sr, sd_r};

  assign x_clip = (rx > 8'(X_MAX)) ? 7'(X_MAX) : rx[6:0];
  assign y_clip = (rx > 8'(Y_MAX)) ? 6'(Y_MAX) : rx[5:0];

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= IDLE;
      sr         <= '0;
      bit_cnt    <= '0;
      x_start    <= '0;
      x_end      <= 7'(X_MAX);
      y_start    <= '0;
      y_end      <= 6'(Y_MAX);
      cur_x      <= '0;
      cur_y      <= '0;
      hi_byte    <= '0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_colour <= '0;
      cmd_valid  <= 1'b0;
      cmd_byte   <= '0;
      frag_err   <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      cmd_valid <= 1'b0;
      frag_err  <= 1'b0;

      if (frag) begin
        bit_cnt  <= '0;
        sr       <= '0;
        frag_err <= 1'b1;
      end else if (shift) begin
        sr      <= rx[6:0];
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (last && !dc_r) begin
        cmd_valid <= 1'b1;
        cmd_byte  <= rx;
        unique case (1'b1)
          (rx == 8'h15): state <= X_START;
          (rx == 8'h75): state <= Y_START;
          (rx == 8'h5C): begin
            state <= PIX_HI;
            cur_x <= x_start;
            cur_y <= y_start;
          end
          default: state <= IDLE;
        endcase
      end else if (last) begin
        unique case (state)
          IDLE: ;
          X_START: begin
            x_start <= x_clip;
            state   <= X_END;
          end
          X_END: begin
            x_end <= (x_clip < x_start) ? x_start : x_clip;
            state <= IDLE;
          end
          Y_START: begin
            y_start <= y_clip;
            state   <= Y_END;
          end
          Y_END: begin
            y_end <= (y_clip < y_start) ? y_start : y_clip;
            state <= IDLE;
          end
          PIX_HI: begin
            hi_byte <= rx;
            state   <= PIX_LO;
          end
          PIX_LO: begin
            pix_valid  <= 1'b1;
            pix_x      <= cur_x;
            pix_y      <= cur_y;
            pix_colour <= {hi_byte, rx};
            state      <= PIX_HI;
            if (cur_x == x_end) begin
              cur_x <= x_start;
              cur_y <= (cur_y == y_end) ? y_start : cur_y + 6'd1;
            end else begin
              cur_x <= cur_x + 7'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
